text_overlay_engine: RTL and testbench



---
 rtl/text_overlay_engine.sv | 107 ++++++++++
 tb/tb_text_overlay_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_engine.sv
// text_overlay_engine: renders a writable NUM_CHARS string at (X0,Y0), scaled by 2**SCALE_LOG2, as a 1-bit is_text stream.
// Define TEXT_BLINK_EN to enable per-character blinking driven by frame_start.
module font_rom (
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [127:0] g;
  always_comb begin
    case (addr[10:4])
      7'h54:   g = 128'h0000FE92101010101010101038000000;
      7'h45:   g = 128'h0000FE6662687868606266FE00000000;
      7'h52:   g = 128'h0000FC6666667C6C666666E600000000;
      7'h49:   g = 128'h00003C181818181818181_83C00000000;
      7'h53:   g = 128'h00007CC6C660380C06C6C67C00000000;
      default: g = '0;
    endcase
  end
  assign data = g[{~addr[3:0], 3'b111} -: 8];
endmodule

module text_overlay_engine #(
  parameter int NUM_CHARS    = 16,
  parameter int X0           = 448,
  parameter int Y0           = 80,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30,
  localparam int IDX_W = $clog2(NUM_CHARS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             frame_start,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_char,
  output logic             wr_ready,
  input  logic             clr,
  output logic             busy,
  output logic             is_text
);
  localparam int W = (NUM_CHARS * 8) << SCALE_LOG2;
  localparam int H = 16 << SCALE_LOG2;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr, slot, waddr;
  logic [7:0] mem [NUM_CHARS];
  logic [7:0] wdata, char1, font_data;
  logic [2:0] col, col1;
  logic [3:0] row, row1;
  logic in_box, in_box1, clearing, we, hide;
  int dx, dy;
  assign clearing = state == CLEAR;
  assign busy     = clearing;
  assign wr_ready = ~clearing;
  // wide signed arithmetic so the box edge never wraps near column 1023
  assign dx     = {22'd0, DrawX} - X0;
  assign dy     = {22'd0, DrawY} - Y0;
  assign in_box = dx >= 0 && dx < W && dy >= 0 && dy < H;
  assign slot   = IDX_W'(dx >>> (3 + SCALE_LOG2));
  assign col    = 3'(dx >>> SCALE_LOG2);
  assign row    = 4'(dy >>> SCALE_LOG2);
  assign we    = clearing | (wr_en & ~clr & ({1'b0, wr_addr} < (IDX_W+1)'(NUM_CHARS)));
  assign waddr = clearing ? ptr : wr_addr;
  assign wdata = clearing ? 8'h20 : wr_char;
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    char1 <= mem[slot];
  end
  font_rom u_font (.addr({char1[6:0], row1}), .data(font_data));
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      in_box1 <= 1'b0;
      col1    <= '0;
      row1    <= '0;
      is_text <= 1'b0;
    end else begin
      state   <= clearing ? (ptr == IDX_W'(NUM_CHARS - 1) ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
      ptr     <= clearing ? ptr + 1'b1 : '0;
      in_box1 <= in_box & ~clearing;
      col1    <= col;
      row1    <= row;
      is_text <= in_box1 & font_data[3'd7 - col1] & ~hide;
    end
  end
`ifdef TEXT_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic phase;
  assign hide = char1[7] & phase;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_start) begin
      fcnt  <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
      phase <= fcnt == FW'(BLINK_FRAMES - 1) ? ~phase : phase;
    end
  end
`else
  logic unused_blink;
  assign hide         = 1'b0;
  assign unused_blink = frame_start ^ char1[7];
`endif
endmodule

// File: tb/tb_text_overlay_engine.sv
// tb_text_overlay_engine: three configurations checked against a per-pixel reference model under random and scanned stimulus.
module tb_text_overlay_engine;
  localparam int BF = 3;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic frame_start = 1'b0, wr_en = 1'b0, clr = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic [2:0] it, bz, wr;
  int errs = 0, checks = 0, frames = 0;
  int nch [3] = '{16, 16, 12};
  int sl [3] = '{0, 1, 0};
  int cnt [3];
  logic [7:0] mbuf [3][16];
  bit pr [3], pa [3];
  string title = "TETRIS";
  string pool = "TERIS ";

  always #5 Clk = ~Clk;

  text_overlay_engine #(.NUM_CHARS(16), .SCALE_LOG2(0), .BLINK_FRAMES(BF)) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .wr_ready(wr[0]), .clr(clr),
    .busy(bz[0]), .is_text(it[0]));
  text_overlay_engine #(.NUM_CHARS(16), .SCALE_LOG2(1), .BLINK_FRAMES(BF)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .wr_ready(wr[1]), .clr(clr),
    .busy(bz[1]), .is_text(it[1]));
  text_overlay_engine #(.NUM_CHARS(12), .SCALE_LOG2(0), .BLINK_FRAMES(BF)) u2 (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .wr_ready(wr[2]), .clr(clr),
    .busy(bz[2]), .is_text(it[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h x=%0d y=%0d t=%0t", tag, got, exp, DrawX, DrawY, $time);
    end
  endtask

  function automatic bit glyph_bit(input logic [6:0] code, input int r, input int c);
    bit [127:0] g;
    case (code)
      7'h54:   g = 128'h0000FE92101010101010101038000000;
      7'h45:   g = 128'h0000FE6662687868606266FE00000000;
      7'h52:   g = 128'h0000FC6666667C6C666666E600000000;
      7'h49:   g = 128'h00003C18181818181818183C00000000;
      7'h53:   g = 128'h00007CC6C660380C06C6C67C00000000;
      default: g = '0;
    endcase
    return g[8 * (15 - r) + 7 - c];
  endfunction

  function automatic void pix(input int i, input int x, input int y, output bit r, output bit a);
    int s, dx, dy;
    logic [7:0] c;
    s = 1 << sl[i];
    dx = x - 448;
    dy = y - 80;
    r = 0;
    a = 0;
    if (cnt[i] != 0 || dx < 0 || dy < 0 || dx >= nch[i] * 8 * s || dy >= 16 * s) return;
    c = mbuf[i][dx / (8 * s)];
    r = glyph_bit(c[6:0], (dy / s) % 16, (dx / s) % 8);
    a = c[7];
  endfunction

  task automatic tick();
    bit r [3], a [3], f [3];
    bit ph;
`ifdef TEXT_BLINK_EN
    ph = ((frames / BF) % 2) == 1;
`else
    ph = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      pix(i, int'(DrawX), int'(DrawY), r[i], a[i]);
      f[i] = pr[i] & ~(pa[i] & ph);
      if (cnt[i] > 0) cnt[i]--;
      else if (clr) begin
        cnt[i] = nch[i];
        for (int k = 0; k < 16; k++) mbuf[i][k] = 8'h20;
      end else if (wr_en && int'(wr_addr) < nch[i]) mbuf[i][wr_addr] = wr_char;
    end
    if (frame_start) frames++;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("is_text%0d", i), 32'(it[i]), 32'(f[i]));
      check($sformatf("busy%0d", i), 32'(bz[i]), 32'(cnt[i] != 0));
      check($sformatf("wr_ready%0d", i), 32'(wr[i]), 32'(cnt[i] == 0));
      pr[i] = r[i];
      pa[i] = a[i];
    end
  endtask

  task automatic put(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pr[i] = 0;
      pa[i] = 0;
      cnt[i] = nch[i];
      for (int k = 0; k < 16; k++) mbuf[i][k] = 8'h20;
    end
    repeat (3) begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        check("rst_is_text", 32'(it[i]), 0);
        check("rst_busy", 32'(bz[i]), 1);
        check("rst_wr_ready", 32'(wr[i]), 0);
      end
    end
    Reset_n = 1'b1;
    for (int n = 0; n < 24; n++) begin
      put($urandom_range(715, 440), $urandom_range(117, 76));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1;
      wr_addr = 4'(k);
      wr_char = k == 0 ? 8'hD4 : 8'(title[k]);
      tick();
    end
    wr_en = 1'b0;
    for (int y = 78; y <= 113; y++)
      for (int x = 444; x <= 708; x++) begin
        put(x, y);
        tick();
      end
    put(460, 84);
    clr = 1'b1;
    wr_en = 1'b1;
    wr_addr = 4'd1;
    wr_char = "S";
    tick();
    clr = 1'b0;
    wr_en = 1'b0;
    repeat (2) tick();
    wr_en = 1'b1;
    wr_addr = 4'd2;
    tick();
    wr_en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      put($urandom_range(600, 448), $urandom_range(95, 80));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1;
      wr_addr = 4'(k);
      wr_char = 8'(title[k]);
      tick();
    end
    wr_en = 1'b0;
    for (int x = 444; x <= 580; x++) begin
      put(x, 84);
      wr_en = x == 475;
      wr_addr = 4'd3;
      wr_char = "I";
      tick();
    end
    wr_en = 1'b1;
    wr_addr = 4'd13;
    wr_char = "E";
    tick();
    wr_en = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      int k;
      put($urandom_range(715, 440), $urandom_range(117, 76));
      wr_en = $urandom_range(3, 0) == 0;
      wr_addr = 4'($urandom_range(15, 0));
      k = $urandom_range(7, 0);
      wr_char = k < 6 ? 8'(pool[k]) : (k == 6 ? 8'h00 : 8'($urandom_range(127, 0)));
      wr_char[7] = 1'($urandom_range(1, 0));
      clr = $urandom_range(499, 0) == 0;
      frame_start = $urandom_range(7, 0) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
